ecg_stim_gen: RTL and testbench



---
 rtl/ecg_stim_if.sv | 12 +
 rtl/ecg_stim_gen.sv | 67 ++++++
 tb/tb_ecg_stim_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ecg_stim_if.sv
// ecg_stim_if: control inputs and sample/marker outputs of the synthetic heartbeat source.
interface ecg_stim_if;
    logic       enable;
    logic [1:0] rate_sel;
    logic       amp_hi;
    logic [2:0] sample;
    logic       sample_valid;
    logic       r_mark;
    logic [7:0] beat_cnt;
    modport master (input enable, rate_sel, amp_hi, output sample, sample_valid, r_mark, beat_cnt);
    modport slave (output enable, rate_sel, amp_hi, input sample, sample_valid, r_mark, beat_cnt);
endinterface

// File: rtl/ecg_stim_gen.sv
// ecg_stim_gen: repeating PQRST heartbeat on a 3-bit sample bus, one sample every SAMPLE_DIV clocks,
// with an R-peak marker and a wrapping beat counter.
module ecg_stim_gen #(
    parameter int SAMPLE_DIV = 4,
    parameter int BEAT_BASE  = 32,
    parameter int BEAT_STEP  = 16
) (
    input logic clk,
    input logic rst,
    ecg_stim_if.master bus
);
    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SAMPLE_DIV - 1);
    typedef enum logic [3:0] {IDLE, P, PQ, Q, R, S, ST, T, BL} state_t;
    state_t state, state_n, seg;
    logic [PW-1:0] pre;
    logic [7:0] pos, pos_n, interval;
    logic [1:0] rate_q;
    logic amp_q, strobe;
    logic [2:0] smp;
    // pos is the index of the last emitted sample within the beat; the segment follows from the next index
    always_comb begin
        strobe = bus.enable && pre == PRE_MAX;
        interval = 8'(BEAT_BASE) + 8'(rate_q) * 8'(BEAT_STEP);
        pos_n = (state == IDLE || pos == interval - 8'd1) ? 8'd0 : pos + 8'd1;
        seg = pos_n < 8'd2 ? P : pos_n == 8'd2 ? PQ : pos_n == 8'd3 ? Q : pos_n == 8'd4 ? R :
              pos_n == 8'd5 ? S : pos_n < 8'd8 ? ST : pos_n < 8'd11 ? T : BL;
        smp = seg == P ? 3'd3 : seg == Q ? 3'd1 : seg == R ? (amp_q ? 3'd7 : 3'd5) : seg == S ? 3'd0 :
              seg == T ? (pos_n == 8'd9 ? 3'd4 : 3'd3) : 3'd2;
        state_n = !bus.enable ? IDLE : strobe ? seg : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            pos <= '0;
            rate_q <= '0;
            amp_q <= 1'b0;
            bus.sample <= 3'd2;
            bus.sample_valid <= 1'b0;
            bus.r_mark <= 1'b0;
            bus.beat_cnt <= '0;
        end else if (!bus.enable) begin
            pre <= '0;
            pos <= '0;
            bus.sample <= 3'd2;
            bus.sample_valid <= 1'b0;
            bus.r_mark <= 1'b0;
        end else begin
            pre <= strobe ? '0 : pre + 1'b1;
            bus.sample_valid <= strobe;
            bus.r_mark <= strobe && seg == R;
            if (strobe) begin
                pos <= pos_n;
                bus.sample <= smp;
                if (seg == R) bus.beat_cnt <= bus.beat_cnt + 8'd1;
                // beat shape controls only change on the first P sample
                if (pos_n == 8'd0) begin
                    rate_q <= bus.rate_sel;
                    amp_q <= bus.amp_hi;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecg_stim_gen.sv
// tb_ecg_stim_gen: directed stimulus pushes expected strobes into a queue; a negedge monitor pops and compares.
module tb_ecg_stim_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int next_t = 0;
    int n0;
    logic [7:0] bc_exp = 8'd0;
    typedef struct {int t; logic [2:0] s; logic r; logic [7:0] bc;} exp_t;
    exp_t q[$];
    ecg_stim_if bus();
    ecg_stim_gen dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        exp_t e;
        if (bus.r_mark && !bus.sample_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL r_mark_alone: r_mark=1 sample_valid=0 at cycle %0d", cyc);
        end
        if (bus.sample_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: cycle %0d sample=%0d r_mark=%0d, none expected", cyc, bus.sample, bus.r_mark);
            end else begin
                e = q.pop_front();
                if (cyc != e.t || bus.sample !== e.s || bus.r_mark !== e.r || bus.beat_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL strobe: got cycle=%0d sample=%0d r_mark=%0d beat_cnt=%0d, expected cycle=%0d sample=%0d r_mark=%0d beat_cnt=%0d",
                             cyc, bus.sample, bus.r_mark, bus.beat_cnt, e.t, e.s, e.r, e.bc);
                end
            end
        end
    end
    function automatic logic [2:0] tsamp(int p, bit amp);
        case (p)
            0, 1: return 3'd3;
            2: return 3'd2;
            3: return 3'd1;
            4: return amp ? 3'd7 : 3'd5;
            5: return 3'd0;
            8, 10: return 3'd3;
            9: return 3'd4;
            default: return 3'd2;
        endcase
    endfunction
    task automatic push_samples(int first, int count, bit amp);
        for (int i = 0; i < count; i++) begin
            if (first + i == 4) bc_exp = bc_exp + 8'd1;
            q.push_back('{next_t, tsamp(first + i, amp), first + i == 4, bc_exp});
            next_t += 4;
        end
    endtask
    task automatic push_beat(int rate, bit amp);
        push_samples(0, 32 + 16 * rate, amp);
    endtask
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic start(logic [1:0] rate, bit amp);
        @(posedge clk);
        #1;
        bus.rate_sel = rate;
        bus.amp_hi = amp;
        bus.enable = 1'b1;
        n0 = cyc;
        next_t = cyc + 4;
    endtask
    task automatic drain(int budget);
        int b = budget;
        while (q.size() > 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d strobes outstanding, expected 0", q.size());
            q.delete();
        end
    endtask
    task automatic stop(string name);
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_idle_sample"}, 32'(bus.sample), 2);
        chk({name, "_beat_cnt"}, 32'(bus.beat_cnt), 32'(bc_exp));
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.rate_sel = 2'd0;
        bus.amp_hi = 1'b1;
        #12;
        chk("reset_sample", 32'(bus.sample), 2);
        chk("reset_valid", 32'(bus.sample_valid), 0);
        chk("reset_r_mark", 32'(bus.r_mark), 0);
        chk("reset_beat_cnt", 32'(bus.beat_cnt), 0);
        wait_until(3);
        rst = 1'b0;
        // basic beat plus the start of the next one at 132 clocks after enable
        start(2'd0, 1'b1);
        push_beat(0, 1'b1);
        push_samples(0, 1, 1'b1);
        drain(400);
        stop("t1");
        // slowest rate with low R amplitude
        start(2'd3, 1'b0);
        repeat (3) push_beat(3, 1'b0);
        drain(1200);
        stop("t2");
        // controls changed mid-beat only affect the following beat
        start(2'd0, 1'b1);
        push_beat(0, 1'b1);
        push_beat(2, 1'b0);
        wait_until(n0 + 29);
        bus.rate_sel = 2'd2;
        bus.amp_hi = 1'b0;
        drain(600);
        stop("t3");
        // one-clock enable drop right after the Q sample
        start(2'd0, 1'b1);
        push_samples(0, 4, 1'b1);
        wait_until(n0 + 16);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_drop_sample", 32'(bus.sample), 2);
        chk("t4_drop_valid", 32'(bus.sample_valid), 0);
        chk("t4_drop_beat_cnt", 32'(bus.beat_cnt), 32'(bc_exp));
        bus.enable = 1'b1;
        next_t = cyc + 4;
        push_beat(0, 1'b1);
        drain(300);
        stop("t4");
        // asynchronous reset during the T segment
        start(2'd0, 1'b1);
        push_samples(0, 9, 1'b1);
        wait_until(n0 + 37);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_sample", 32'(bus.sample), 2);
        chk("t5_rst_valid", 32'(bus.sample_valid), 0);
        chk("t5_rst_r_mark", 32'(bus.r_mark), 0);
        chk("t5_rst_beat_cnt", 32'(bus.beat_cnt), 0);
        chk("t5_pre_rst_drained", 32'(q.size()), 0);
        q.delete();
        bc_exp = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        next_t = cyc + 4;
        push_beat(0, 1'b1);
        drain(300);
        stop("t5");
        // beat counter wraps on the 256th R peak
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bc_exp = 8'd0;
        start(2'd0, 1'b1);
        repeat (256) push_beat(0, 1'b1);
        drain(34000);
        stop("t6");
        chk("t6_wrap_beat_cnt", 32'(bus.beat_cnt), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
